tx_bank_sched: RTL and testbench

- Sequences the banked TX buffer shared by the command decoder (writer) and the USB slave-FIFO transmit path (reader). All logic runs in the mclk domain.
- Bank 0 is reserved for handshake replies. Banks 1..NBANK-1 form a data ring.
- Grants banks to the writer and commits filled banks. Issues one transmit start per committed bank, then frees the bank on completion.
- Handshake traffic has priority. A ring-full condition back-pressures the writer instead of overwriting unsent data.

---
 rtl/tx_bank_sched_pkg.sv | 19 +
 rtl/tx_bank_sched_if.sv | 34 +++
 rtl/tx_bank_sched_bank_ring_ptr.sv | 30 +++
 rtl/tx_bank_sched.sv | 153 +++++++++++++++
 tb/tb_tx_bank_sched.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_bank_sched_pkg.sv
// Shared definitions for the banked TX buffer scheduler.
package tx_bank_sched_pkg;

  localparam int unsigned BUFFER_BADDR_NBIT = 2;
  // Bank reserved for handshake replies; never part of the data ring.
  localparam int unsigned HS_BANK = 0;

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_COMMIT
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_SEND
  } rd_state_e;

endpackage

// File: rtl/tx_bank_sched_if.sv
// Writer/reader handshake bundle between the scheduler and its clients.
interface tx_bank_sched_if
  import tx_bank_sched_pkg::*;
#(
  parameter int unsigned BADDR_NBIT = BUFFER_BADDR_NBIT,
  parameter int unsigned LVL_NBIT   = BADDR_NBIT
);

  logic                  hs_req;
  logic                  data_req;
  logic                  wr_grant;
  logic [BADDR_NBIT-1:0] wr_baddr;
  logic                  wr_busy;
  logic                  wr_eop;
  logic                  rd_full;
  logic                  rd_done;
  logic                  tx_sop;
  logic [BADDR_NBIT-1:0] tx_baddr;
  logic [LVL_NBIT-1:0]   data_level;
  logic [7:0]            drop_cnt;

  // Client side: command decoder and USB transmit path.
  modport master (
    output hs_req, data_req, wr_eop, rd_full, rd_done,
    input  wr_grant, wr_baddr, wr_busy, tx_sop, tx_baddr, data_level, drop_cnt
  );

  // Scheduler side.
  modport slave (
    input  hs_req, data_req, wr_eop, rd_full, rd_done,
    output wr_grant, wr_baddr, wr_busy, tx_sop, tx_baddr, data_level, drop_cnt
  );

endinterface

// File: rtl/tx_bank_sched_bank_ring_ptr.sv
// Data-ring bank pointer: resets to 1 and wraps NBANK-1 -> 1, skipping bank 0.
module bank_ring_ptr #(
  parameter int unsigned BADDR_NBIT = 2
) (
  input  logic                  mclk,
  input  logic                  rst_n,
  input  logic                  adv,
  output logic [BADDR_NBIT-1:0] ptr
);

  localparam logic [BADDR_NBIT-1:0] FIRST = BADDR_NBIT'(1);
  localparam logic [BADDR_NBIT-1:0] LAST  = BADDR_NBIT'((2 ** BADDR_NBIT) - 1);

  logic [BADDR_NBIT-1:0] ptr_q, ptr_d;

  // Advance with wrap past the reserved handshake bank.
  always_comb begin
    ptr_d = ptr_q;
    if (adv) ptr_d = (ptr_q == LAST) ? FIRST : ptr_q + 1'b1;
  end

  // Pointer register.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) ptr_q <= FIRST;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/tx_bank_sched.sv
// Banked TX buffer scheduler: grants banks to the writer, sends committed banks,
// handshake bank first, and back-pressures the writer when the data ring is full.
module tx_bank_sched
  import tx_bank_sched_pkg::*;
#(
  parameter int unsigned BADDR_NBIT = BUFFER_BADDR_NBIT,
  parameter int unsigned LVL_NBIT   = BADDR_NBIT
) (
  input logic             mclk,
  input logic             rst_n,
  tx_bank_sched_if.slave  bus
);

  localparam int unsigned           NBANK    = 2 ** BADDR_NBIT;
  localparam logic [LVL_NBIT-1:0]   LVL_FULL = LVL_NBIT'(NBANK - 1);
  localparam logic [BADDR_NBIT-1:0] HS_BADDR = BADDR_NBIT'(HS_BANK);

  wr_state_e             wr_state_q, wr_state_d;
  rd_state_e             rd_state_q, rd_state_d;
  logic                  wr_grant_q, wr_grant_d;
  logic [BADDR_NBIT-1:0] wr_baddr_q, wr_baddr_d;
  logic                  tx_sop_q, tx_sop_d;
  logic [BADDR_NBIT-1:0] tx_baddr_q, tx_baddr_d;
  logic                  hs_pend_q, hs_pend_d;
  logic [LVL_NBIT-1:0]   level_q, level_d;
  logic [7:0]            drop_q, drop_d;
  logic                  commit_hs, commit_data, done_hs, done_data;
  logic [BADDR_NBIT-1:0] wr_ptr, rd_ptr;

  bank_ring_ptr #(.BADDR_NBIT(BADDR_NBIT)) u_wr_ptr (
    .mclk  (mclk),
    .rst_n (rst_n),
    .adv   (commit_data),
    .ptr   (wr_ptr)
  );

  bank_ring_ptr #(.BADDR_NBIT(BADDR_NBIT)) u_rd_ptr (
    .mclk  (mclk),
    .rst_n (rst_n),
    .adv   (done_data),
    .ptr   (rd_ptr)
  );

  // Writer FSM: grant a free bank (handshake first), wait for eop, commit.
  always_comb begin
    wr_state_d  = wr_state_q;
    wr_grant_d  = 1'b0;
    wr_baddr_d  = wr_baddr_q;
    drop_d      = drop_q;
    commit_hs   = 1'b0;
    commit_data = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        if (bus.hs_req && !hs_pend_q) begin
          wr_grant_d = 1'b1;
          wr_baddr_d = HS_BADDR;
          wr_state_d = W_FILL;
        end else if (bus.data_req) begin
          if (level_q != LVL_FULL) begin
            wr_grant_d = 1'b1;
            wr_baddr_d = wr_ptr;
            wr_state_d = W_FILL;
          end else if (drop_q != 8'hff) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      W_FILL: begin
        if (bus.wr_eop) wr_state_d = W_COMMIT;
      end
      W_COMMIT: begin
        wr_state_d = W_IDLE;
        if (wr_baddr_q == HS_BADDR) commit_hs = 1'b1;
        else                        commit_data = 1'b1;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Reader FSM: handshake ignores rd_full; data waits for room in EP6.
  always_comb begin
    rd_state_d = rd_state_q;
    tx_sop_d   = 1'b0;
    tx_baddr_d = tx_baddr_q;
    done_hs    = 1'b0;
    done_data  = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        if (hs_pend_q) begin
          tx_sop_d   = 1'b1;
          tx_baddr_d = HS_BADDR;
          rd_state_d = R_SEND;
        end else if (level_q != '0 && !bus.rd_full) begin
          tx_sop_d   = 1'b1;
          tx_baddr_d = rd_ptr;
          rd_state_d = R_SEND;
        end
      end
      R_SEND: begin
        if (bus.rd_done) begin
          rd_state_d = R_IDLE;
          if (tx_baddr_q == HS_BADDR) done_hs = 1'b1;
          else                        done_data = 1'b1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Occupancy bookkeeping; a commit and a completion in one cycle cancel out.
  always_comb begin
    hs_pend_d = hs_pend_q;
    if (commit_hs) hs_pend_d = 1'b1;
    if (done_hs)   hs_pend_d = 1'b0;
    level_d = level_q;
    if (commit_data && !done_data)      level_d = level_q + 1'b1;
    else if (done_data && !commit_data) level_d = level_q - 1'b1;
  end

  // State and output registers.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      wr_grant_q <= 1'b0;
      wr_baddr_q <= '0;
      tx_sop_q   <= 1'b0;
      tx_baddr_q <= '0;
      hs_pend_q  <= 1'b0;
      level_q    <= '0;
      drop_q     <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_grant_q <= wr_grant_d;
      wr_baddr_q <= wr_baddr_d;
      tx_sop_q   <= tx_sop_d;
      tx_baddr_q <= tx_baddr_d;
      hs_pend_q  <= hs_pend_d;
      level_q    <= level_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.wr_grant   = wr_grant_q;
  assign bus.wr_baddr   = wr_baddr_q;
  assign bus.wr_busy    = (wr_state_q != W_IDLE);
  assign bus.tx_sop     = tx_sop_q;
  assign bus.tx_baddr   = tx_baddr_q;
  assign bus.data_level = level_q;
  assign bus.drop_cnt   = drop_q;

endmodule

// File: tb/tb_tx_bank_sched.sv
// Self-checking bench for tx_bank_sched: directed scenarios then randomized
// transactions checked against a queue-based model of the bank ring.
module tb_tx_bank_sched;

  localparam int NB    = 2;
  localparam int NBANK = 4;

  logic mclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 mclk = ~mclk;

  tx_bank_sched_if #(.BADDR_NBIT(NB), .LVL_NBIT(NB)) bus ();

  tx_bank_sched #(.BADDR_NBIT(NB), .LVL_NBIT(NB)) dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  int sop_q[$];

  // Record every transmit start with its bank.
  always @(negedge mclk) begin
    if (bus.tx_sop) sop_q.push_back(int'(bus.tx_baddr));
  end

  task automatic tick();
    @(negedge mclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " wr_grant"}, 32'(bus.wr_grant), 0);
    check({tag, " wr_baddr"}, 32'(bus.wr_baddr), 0);
    check({tag, " wr_busy"}, 32'(bus.wr_busy), 0);
    check({tag, " tx_sop"}, 32'(bus.tx_sop), 0);
    check({tag, " tx_baddr"}, 32'(bus.tx_baddr), 0);
    check({tag, " data_level"}, 32'(bus.data_level), 0);
    check({tag, " drop_cnt"}, 32'(bus.drop_cnt), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.hs_req = 0; bus.data_req = 0; bus.wr_eop = 0; bus.rd_full = 1; bus.rd_done = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    sop_q.delete();
  endtask

  task automatic wait_grant(output bit got);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.wr_grant) begin
        got = 1;
        break;
      end
    end
  endtask

  // Request, expect a grant of exp_bank, fill, commit. Optionally complete a
  // read in the same cycle as the commit.
  task automatic write_bank(input bit rq_hs, input bit rq_data, input int fill,
                            input int exp_bank, input bit done_at_commit, input string tag);
    bit got;
    bus.hs_req = rq_hs;
    bus.data_req = rq_data;
    wait_grant(got);
    bus.hs_req = 0;
    bus.data_req = 0;
    check({tag, " grant"}, 32'(got), 1);
    if (got) begin
      check({tag, " wr_baddr"}, 32'(bus.wr_baddr), 32'(exp_bank));
      check({tag, " busy"}, 32'(bus.wr_busy), 1);
      repeat (fill) tick();
      bus.wr_eop = 1;
      tick();
      bus.wr_eop = 0;
      bus.rd_done = done_at_commit;
      tick();
      bus.rd_done = 0;
      check({tag, " idle"}, 32'(bus.wr_busy), 0);
    end
  endtask

  task automatic expect_sop(input int exp_bank, input string tag);
    for (int i = 0; i < 20 && sop_q.size() == 0; i++) tick();
    check({tag, " sop seen"}, 32'(sop_q.size() > 0), 1);
    if (sop_q.size() > 0) begin
      check({tag, " sop bank"}, 32'(sop_q.pop_front()), 32'(exp_bank));
      check({tag, " tx_baddr"}, 32'(bus.tx_baddr), 32'(exp_bank));
    end
  endtask

  task automatic finish_read(input int delay);
    repeat (delay) tick();
    bus.rd_done = 1;
    tick();
    bus.rd_done = 0;
    tick();
  endtask

  task automatic no_grant_for(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, 32'(bus.wr_grant), 0);
    end
  endtask

  initial begin
    bit got;
    int m_q[$];
    bit m_hs;
    int m_wp;
    int m_drop;
    int k;

    bus.hs_req = 0; bus.data_req = 0; bus.wr_eop = 0; bus.rd_full = 1; bus.rd_done = 0;
    repeat (2) tick();
    check_all_zero("reset");
    do_reset();

    // Handshake priority; eop and rd_done while idle are ignored.
    bus.wr_eop = 1; bus.rd_done = 1;
    tick();
    bus.wr_eop = 0; bus.rd_done = 0;
    tick();
    check("stray eop busy", 32'(bus.wr_busy), 0);
    check("stray done sop", 32'(sop_q.size()), 0);
    write_bank(1, 1, 0, 0, 0, "hs_prio");
    expect_sop(0, "hs_sop_full");
    finish_read(2);
    write_bank(0, 1, 1, 1, 0, "after_hs");
    check("after_hs level", 32'(bus.data_level), 1);

    // Ring fill and refused requests.
    do_reset();
    for (int b = 1; b <= 3; b++) write_bank(0, 1, b - 1, b, 0, "fill");
    check("fill level", 32'(bus.data_level), 3);
    bus.data_req = 1;
    no_grant_for(5, "full no grant");
    bus.data_req = 0;
    tick();
    check("full drop_cnt", 32'(bus.drop_cnt), 5);

    // Drain in order and wrap.
    bus.rd_full = 0;
    for (int b = 1; b <= 3; b++) begin
      expect_sop(b, "drain");
      finish_read(1);
    end
    check("drain level", 32'(bus.data_level), 0);
    bus.rd_full = 1;
    write_bank(0, 1, 0, 1, 0, "wrap");

    // Commit and completion in the same cycle.
    bus.rd_full = 0;
    expect_sop(1, "simul send");
    bus.rd_full = 1;
    write_bank(0, 1, 2, 2, 1, "simul");
    check("simul level", 32'(bus.data_level), 1);
    check("simul no extra sop", 32'(sop_q.size()), 0);
    bus.rd_full = 0;
    expect_sop(2, "simul next");
    bus.rd_full = 1;
    finish_read(0);
    check("simul drained", 32'(bus.data_level), 0);

    // Handshake blocked while the previous reply is outstanding.
    write_bank(1, 0, 1, 0, 0, "hs1");
    expect_sop(0, "hs1 send");
    bus.hs_req = 1;
    no_grant_for(4, "hs blocked");
    write_bank(1, 1, 0, 3, 0, "data_during_hs");
    bus.hs_req = 1;
    no_grant_for(3, "hs still blocked");
    bus.rd_done = 1;
    tick();
    bus.rd_done = 0;
    wait_grant(got);
    bus.hs_req = 0;
    check("hs regrant", 32'(got), 1);
    check("hs regrant bank", 32'(bus.wr_baddr), 0);
    bus.wr_eop = 1;
    tick();
    bus.wr_eop = 0;
    tick();
    expect_sop(0, "hs2 send");
    finish_read(1);
    check("hs level", 32'(bus.data_level), 1);

    // Asynchronous reset in the middle of a fill.
    do_reset();
    write_bank(0, 1, 0, 1, 0, "pre_rst");
    bus.data_req = 1;
    wait_grant(got);
    bus.data_req = 0;
    check("rst fill grant", 32'(got), 1);
    check("rst fill bank", 32'(bus.wr_baddr), 2);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async rst");
    repeat (2) tick();
    rst_n = 1'b1;
    bus.rd_full = 0;
    sop_q.delete();
    repeat (20) tick();
    check("post rst sop", 32'(sop_q.size()), 0);
    check("post rst level", 32'(bus.data_level), 0);

    // Randomized transactions against the ring model.
    do_reset();
    m_q.delete();
    m_hs = 0;
    m_wp = 1;
    m_drop = 0;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          if (m_q.size() == NBANK - 1) begin
            k = $urandom_range(1, 4);
            bus.data_req = 1;
            no_grant_for(k, "rnd full");
            bus.data_req = 0;
            tick();
            m_drop = (m_drop + k > 255) ? 255 : m_drop + k;
            check("rnd drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
          end else begin
            write_bank(0, 1, $urandom_range(0, 3), m_wp, 0, "rnd data");
            m_q.push_back(m_wp);
            m_wp = (m_wp == NBANK - 1) ? 1 : m_wp + 1;
          end
        end
        1: begin
          if (m_hs) begin
            bus.hs_req = 1;
            no_grant_for(3, "rnd hs blocked");
            bus.hs_req = 0;
            tick();
          end else begin
            write_bank(1, 0, $urandom_range(0, 3), 0, 0, "rnd hs");
            m_hs = 1;
          end
        end
        default: begin
          if (m_hs) begin
            expect_sop(0, "rnd hs read");
            finish_read($urandom_range(0, 3));
            m_hs = 0;
          end else if (m_q.size() > 0) begin
            bus.rd_full = 0;
            expect_sop(m_q[0], "rnd data read");
            bus.rd_full = 1;
            finish_read($urandom_range(0, 3));
            void'(m_q.pop_front());
          end else begin
            bus.rd_full = 0;
            repeat (6) tick();
            bus.rd_full = 1;
            check("rnd empty no sop", 32'(sop_q.size()), 0);
          end
        end
      endcase
      check("rnd level", 32'(bus.data_level), 32'(m_q.size()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
